multi_cycle_sequencer: RTL and testbench

- Sequences each instruction of the multi-period MIPS core through IF/ID/EX/MEM/WB.
- Consumes the decoded flags from the combinational control unit and produces the per-cycle datapath strobes and mux selects: PC/IR write, memory strobes, register-file write, ALU operand selects.
- Sits between the control unit and the datapath, and handles variable-latency memory through a mem_ready handshake.

---
 rtl/multi_cycle_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_multi_cycle_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_sequencer.sv
// Per-instruction control sequencer for the multi-cycle MIPS core.
// Walks IF/ID/EX/MEM/WB and decodes the datapath strobes from state, latched flags and handshakes.
module multi_cycle_sequencer #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reg_dst_flag,
  input  logic                   alu_src_flag,
  input  logic                   mem_to_reg_flag,
  input  logic                   reg_write_flag,
  input  logic                   mem_read_flag,
  input  logic                   mem_write_flag,
  input  logic                   branch_flag,
  input  logic                   jump_flag,
  input  logic                   alu_zero,
  input  logic                   mem_ready,
  output logic                   imem_read,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   target_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic                   alu_op_sel,
  output logic                   dmem_read,
  output logic                   dmem_write,
  output logic                   rf_write,
  output logic                   rf_dst,
  output logic                   rf_mem_to_reg,
  output logic [2:0]             state,
  output logic                   retire,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } flags_t;

  state_t                 state_q, state_d;
  flags_t                 flags_q, flags_d, flags_in;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  assign flags_in = {reg_dst_flag, alu_src_flag, mem_to_reg_flag, reg_write_flag,
                     mem_read_flag, mem_write_flag, branch_flag, jump_flag};

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      flags_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    flags_d      = flags_q;
    imem_read    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    target_write = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op_sel   = 1'b0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    rf_write     = 1'b0;
    retire       = 1'b0;

    case (state_q)
      S_IF: begin
        imem_read = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        // Branch target (PC+4 + imm<<2) is computed here, speculatively.
        alu_src_b    = 2'b11;
        target_write = 1'b1;
        flags_d      = flags_in;
        if (jump_flag) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          retire   = 1'b1;
          state_d  = S_IF;
        end else if (!(branch_flag || reg_write_flag || mem_read_flag || mem_write_flag)) begin
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_src_a  = 1'b1;
        alu_op_sel = 1'b1;
        alu_src_b  = flags_q.alu_src ? 2'b10 : 2'b00;
        if (flags_q.branch) begin
          pc_write = alu_zero;
          pc_src   = 2'b01;
          retire   = 1'b1;
          state_d  = S_IF;
        end else if (flags_q.mem_read || flags_q.mem_write) begin
          state_d = S_MEM;
        end else if (flags_q.reg_write) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        dmem_read  = flags_q.mem_read;
        dmem_write = flags_q.mem_write;
        if (mem_ready) begin
          if (flags_q.mem_read) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_IF;
          end
        end
      end
      S_WB: begin
        rf_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset kills all strobes in the same cycle so an aborted instruction never retires.
    if (rst) begin
      imem_read    = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      target_write = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_op_sel   = 1'b0;
      dmem_read    = 1'b0;
      dmem_write   = 1'b0;
      rf_write     = 1'b0;
      retire       = 1'b0;
    end

    count_d = count_q + COUNT_WIDTH'(retire);
  end

  assign rf_dst        = flags_q.reg_dst & ~rst;
  assign rf_mem_to_reg = flags_q.mem_to_reg & ~rst;
  assign state         = state_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Randomised bench for multi_cycle_sequencer: a per-instruction phase model predicts every
// cycle's strobes and the retired count (narrow counter so wrap-around is exercised).
module tb_multi_cycle_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_dst_flag, alu_src_flag, mem_to_reg_flag, reg_write_flag;
  logic          mem_read_flag, mem_write_flag, branch_flag, jump_flag;
  logic          alu_zero, mem_ready;
  logic          imem_read, ir_write, pc_write, target_write, alu_src_a, alu_op_sel;
  logic          dmem_read, dmem_write, rf_write, rf_dst, rf_mem_to_reg, retire;
  logic [1:0]    pc_src, alu_src_b;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  multi_cycle_sequencer #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .reg_dst_flag(reg_dst_flag), .alu_src_flag(alu_src_flag), .mem_to_reg_flag(mem_to_reg_flag),
    .reg_write_flag(reg_write_flag), .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .branch_flag(branch_flag), .jump_flag(jump_flag), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .imem_read(imem_read), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .target_write(target_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op_sel(alu_op_sel), .dmem_read(dmem_read), .dmem_write(dmem_write), .rf_write(rf_write),
    .rf_dst(rf_dst), .rf_mem_to_reg(rf_mem_to_reg), .state(state), .retire(retire),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_read, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       target_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op_sel, dmem_read, dmem_write, rf_write, rf_dst, rf_mem_to_reg, retire;
  } obs_t;

  typedef struct packed {
    logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump;
  } fl_t;

  typedef enum {P_IFW, P_IFG, P_ID, P_EX, P_MEMW, P_MEMG, P_WB} phase_t;

  int  total = 0;
  int  bad   = 0;
  int  retired = 0;
  fl_t lat = '0;

  localparam fl_t F_ADD  = 8'b1001_0000;
  localparam fl_t F_LW   = 8'b0111_1000;
  localparam fl_t F_SW   = 8'b0100_0100;
  localparam fl_t F_BEQ  = 8'b0000_0010;
  localparam fl_t F_J    = 8'b0000_0001;
  localparam fl_t F_NOP  = 8'b0000_0000;
  localparam fl_t F_ADDI = 8'b0101_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.st = state; o.imem_read = imem_read; o.ir_write = ir_write; o.pc_write = pc_write;
    o.pc_src = pc_src; o.target_write = target_write; o.alu_src_a = alu_src_a;
    o.alu_src_b = alu_src_b; o.alu_op_sel = alu_op_sel; o.dmem_read = dmem_read;
    o.dmem_write = dmem_write; o.rf_write = rf_write; o.rf_dst = rf_dst;
    o.rf_mem_to_reg = rf_mem_to_reg; o.retire = retire;
    return o;
  endfunction

  function automatic logic any_op(input fl_t f);
    return f.branch | f.reg_write | f.mem_read | f.mem_write;
  endfunction

  // Expected strobes for one cycle of an instruction, given the phase it is in.
  function automatic obs_t expect_of(input phase_t p, input fl_t f, input logic zero, input fl_t held);
    obs_t e = '0;
    e.rf_dst        = held.reg_dst;
    e.rf_mem_to_reg = held.mem_to_reg;
    case (p)
      P_IFW, P_IFG: begin
        e.st = 3'd0; e.imem_read = 1'b1; e.alu_src_b = 2'b01;
        if (p == P_IFG) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      end
      P_ID: begin
        e.st = 3'd1; e.alu_src_b = 2'b11; e.target_write = 1'b1;
        if (f.jump) begin e.pc_write = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1; end
        else if (!any_op(f)) e.retire = 1'b1;
      end
      P_EX: begin
        e.st = 3'd2; e.alu_src_a = 1'b1; e.alu_op_sel = 1'b1;
        e.alu_src_b = f.alu_src ? 2'b10 : 2'b00;
        if (f.branch) begin e.pc_write = zero; e.pc_src = 2'b01; e.retire = 1'b1; end
      end
      P_MEMW, P_MEMG: begin
        e.st = 3'd3; e.dmem_read = f.mem_read; e.dmem_write = f.mem_write;
        if (p == P_MEMG && !f.mem_read) e.retire = 1'b1;
      end
      default: begin
        e.st = 3'd4; e.rf_write = 1'b1; e.retire = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic drive_flags(input fl_t f);
    {reg_dst_flag, alu_src_flag, mem_to_reg_flag, reg_write_flag,
     mem_read_flag, mem_write_flag, branch_flag, jump_flag} = f;
  endtask

  task automatic run_cycle(input phase_t p, input fl_t f, input logic zero, input string tag);
    obs_t e;
    @(negedge clk);
    rst = 1'b0;
    // Outside the cycles where they matter, inputs carry noise the DUT must ignore.
    drive_flags((p == P_ID) ? f : fl_t'($urandom_range(0, 255)));
    case (p)
      P_IFW, P_MEMW: mem_ready = 1'b0;
      P_IFG, P_MEMG: mem_ready = 1'b1;
      default:       mem_ready = 1'($urandom_range(0, 1));
    endcase
    alu_zero = (p == P_EX) ? zero : 1'($urandom_range(0, 1));
    #1;
    e = expect_of(p, f, zero, lat);
    check(tag, 64'(observe()), 64'(e));
    check({tag, "_count"}, 64'(instr_count), 64'(retired % (1 << CW)));
    if (e.retire) retired++;
    if (p == P_ID) lat = f;
  endtask

  task automatic run_instr(input fl_t f, input int w_if, input int w_mem, input logic zero,
                           input string tag);
    repeat (w_if) run_cycle(P_IFW, f, zero, {tag, "_ifw"});
    run_cycle(P_IFG, f, zero, {tag, "_if"});
    run_cycle(P_ID, f, zero, {tag, "_id"});
    if (f.jump || !any_op(f)) return;
    run_cycle(P_EX, f, zero, {tag, "_ex"});
    if (f.branch) return;
    if (f.mem_read || f.mem_write) begin
      repeat (w_mem) run_cycle(P_MEMW, f, zero, {tag, "_memw"});
      run_cycle(P_MEMG, f, zero, {tag, "_mem"});
      if (!f.mem_read) return;
    end
    run_cycle(P_WB, f, zero, {tag, "_wb"});
  endtask

  function automatic fl_t rand_instr();
    fl_t f;
    case ($urandom_range(0, 6))
      0:       f = F_ADD;
      1:       f = F_ADDI;
      2:       f = F_LW;
      3:       f = F_SW;
      4:       f = F_BEQ;
      5:       f = F_J;
      default: f = F_NOP;
    endcase
    // Don't-care bits that only show up on rf_dst/rf_mem_to_reg.
    if (f == F_NOP || f == F_J) begin
      f.reg_dst    = 1'($urandom_range(0, 1));
      f.mem_to_reg = 1'($urandom_range(0, 1));
      f.alu_src    = 1'($urandom_range(0, 1));
    end
    return f;
  endfunction

  initial begin
    obs_t e;
    rst = 1'b1;
    drive_flags(F_LW);
    mem_ready = 1'b1;
    alu_zero  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    e = '0;
    check("reset_outputs", 64'(observe()), 64'(e));
    check("reset_count", 64'(instr_count), 64'd0);

    run_instr(F_ADD, 0, 0, 1'b0, "add");
    run_instr(F_LW,  0, 0, 1'b0, "lw");
    run_instr(F_SW,  0, 3, 1'b0, "sw_wait3");
    run_instr(F_BEQ, 0, 0, 1'b1, "beq_taken");
    run_instr(F_BEQ, 0, 0, 1'b0, "beq_not_taken");
    run_instr(F_J,   0, 0, 1'b0, "j");
    run_instr(F_NOP, 0, 0, 1'b0, "illegal");

    for (int i = 0; i < 40; i++) begin
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), "rand");
    end

    // Abort a store mid-MEM with reset.
    run_cycle(P_IFG,  F_SW, 1'b0, "abort_if");
    run_cycle(P_ID,   F_SW, 1'b0, "abort_id");
    run_cycle(P_EX,   F_SW, 1'b0, "abort_ex");
    run_cycle(P_MEMW, F_SW, 1'b0, "abort_memw");
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b1;
    #1;
    e    = '0;
    e.st = 3'd3;
    check("abort_rst_cycle", 64'(observe()), 64'(e));
    lat     = '0;
    retired = 0;
    run_cycle(P_IFW, F_ADD, 1'b0, "after_abort_ifw");
    run_cycle(P_IFW, F_ADD, 1'b0, "after_abort_ifw2");
    run_instr(F_ADD, 1, 0, 1'b0, "after_abort_add");
    run_instr(F_LW,  0, 2, 1'b0, "after_abort_lw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
